// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Display back end for the 8-bit up/down counter. It converts the counter
//   value to three BCD digits with a sequential double-dabble engine. The
//   result drives a 4-digit multiplexed common-anode seven-segment display.
//   Digits 0..2 show the value in decimal, with leading zeros blanked.
//   Digit 3 shows 'U' (counting up) or 'd' (counting down).
//
// Parameters
//   SCAN_DIV : clk cycles each digit stays lit (minimum 2)
//
// Ports
//   clk   in   system clock
//   clr   in   asynchronous, active-high reset
//   value in   [7:0] binary value to display (counter q)
//   mode  in   direction flag: 0 = up, 1 = down (used live by the scanner)
//   seg   out  [6:0] segment drive {g,f,e,d,c,b,a}, active-low, registered
//   an    out  [3:0] digit enable, one-hot active-low, registered;
//              bit 0 = ones digit, bit 3 = mode letter
//   busy  out  high while a conversion is in SHIFT or UPDATE
module seg_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] value,
    input  logic       mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_U     = 7'b1000001;
    localparam logic [6:0]  SEG_D     = 7'b0100001;

    state_t      state;
    logic [19:0] work;
    logic [2:0]  it;
    logic [3:0]  ones, tens, hund;
    logic [19:0] adj;
    logic [15:0] prescaler;
    logic [1:0]  idx;
    logic [6:0]  digit_code;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: each BCD nibble that is 5 or more gets +3
    // before the shift, so it carries correctly into the next decade.
    assign adj = {add3(work[19:16]), add3(work[15:12]), add3(work[11:8]), work[7:0]};

    // Converter FSM. busy is registered from the next state, so it is high
    // for the SHIFT x8 + UPDATE cycles that follow each IDLE capture.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            work  <= '0;
            it    <= '0;
            ones  <= '0;
            tens  <= '0;
            hund  <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    work  <= {12'b0, value};
                    it    <= '0;
                    state <= SHIFT;
                    busy  <= 1'b1;
                end
                SHIFT: begin
                    work <= adj << 1;
                    it   <= it + 3'd1;
                    busy <= 1'b1;
                    if (it == 3'd7) state <= UPDATE;
                end
                UPDATE: begin
                    ones  <= work[11:8];
                    tens  <= work[15:12];
                    hund  <= work[19:16];
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scanner: the prescaler sets how long each digit stays lit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == DIV_LAST) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // Digit content for the selected position, with leading zeros blanked.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        digit_code = SEG_BLANK;
        case (idx)
            2'd0: digit_code = seg_code(ones);
            2'd1: if (!(hund == 4'd0 && tens == 4'd0)) digit_code = seg_code(tens);
            2'd2: if (hund != 4'd0) digit_code = seg_code(hund);
            2'd3: digit_code = mode ? SEG_D : SEG_U;
            default: digit_code = SEG_BLANK;
        endcase
    end

    // Output registers: these lag idx and the digit registers by one cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= digit_code;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
//   Directed bench for seg_scan_display with SCAN_DIV = 4. Inputs change and
//   outputs are sampled on the falling clock edge. The DUT acts on the rising edge.
module tb_seg_scan_display;

    logic       clk;
    logic       clr;
    logic [7:0] value;
    logic       mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int vectors;
    int miscompares;

    seg_scan_display #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .clr   (clr),
        .value (value),
        .mode  (mode),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until the given digit is enabled.
    task automatic wait_an(input logic [3:0] target, input string name);
        int n;
        n = 0;
        while (an !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (an !== target) begin
            miscompares++;
            $display("FAIL %s: an never reached %b (got %b)", name, target, an);
        end
    endtask

    // Wait (bounded) for the converter to sit in IDLE, then step across the
    // capture edge. The bench is then one cycle after an IDLE capture.
    task automatic sync_capture(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: busy never dropped (got %b)", name, busy);
        end
        step(1);
    endtask

    task automatic test_reset;
        clr   = 1'b1;
        value = 8'd123;
        mode  = 1'b0;
        step(3);
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL reset_an: got %b want 1111", an); end
        vectors++;
        if (seg !== 7'b1111111) begin miscompares++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        clr = 1'b0;
        step(1);
        vectors++;
        if (an !== 4'b1110) begin miscompares++; $display("FAIL release_an: got %b want 1110", an); end
        vectors++;
        if (seg !== 7'b1000000) begin miscompares++; $display("FAIL release_seg: got %b want 1000000", seg); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL release_busy: got %b want 1", busy); end
    endtask

    task automatic test_full_range;
        value = 8'd255;
        mode  = 1'b0;
        step(30);
        vectors++;
        if ({dut.hund, dut.tens, dut.ones} !== 12'h255) begin
            miscompares++;
            $display("FAIL full_digits: got %h want 255", {dut.hund, dut.tens, dut.ones});
        end
        wait_an(4'b1110, "full_an0");
        vectors++;
        if (seg !== 7'b0010010) begin miscompares++; $display("FAIL full_ones: got %b want 0010010", seg); end
        wait_an(4'b1101, "full_an1");
        vectors++;
        if (seg !== 7'b0010010) begin miscompares++; $display("FAIL full_tens: got %b want 0010010", seg); end
        wait_an(4'b1011, "full_an2");
        vectors++;
        if (seg !== 7'b0100100) begin miscompares++; $display("FAIL full_hund: got %b want 0100100", seg); end
        wait_an(4'b0111, "full_an3");
        vectors++;
        if (seg !== 7'b1000001) begin miscompares++; $display("FAIL full_mode_u: got %b want 1000001", seg); end
    endtask

    task automatic test_blanking;
        value = 8'd7;
        step(30);
        wait_an(4'b1101, "blank7_an1");
        vectors++;
        if (seg !== 7'b1111111) begin miscompares++; $display("FAIL blank7_tens: got %b want 1111111", seg); end
        wait_an(4'b1011, "blank7_an2");
        vectors++;
        if (seg !== 7'b1111111) begin miscompares++; $display("FAIL blank7_hund: got %b want 1111111", seg); end
        wait_an(4'b1110, "blank7_an0");
        vectors++;
        if (seg !== 7'b1111000) begin miscompares++; $display("FAIL blank7_ones: got %b want 1111000", seg); end

        value = 8'd100;
        step(30);
        wait_an(4'b1101, "v100_an1");
        vectors++;
        if (seg !== 7'b1000000) begin miscompares++; $display("FAIL v100_tens: got %b want 1000000", seg); end
        wait_an(4'b1011, "v100_an2");
        vectors++;
        if (seg !== 7'b1111001) begin miscompares++; $display("FAIL v100_hund: got %b want 1111001", seg); end
        wait_an(4'b1110, "v100_an0");
        vectors++;
        if (seg !== 7'b1000000) begin miscompares++; $display("FAIL v100_ones: got %b want 1000000", seg); end
    endtask

    task automatic test_mode;
        value = 8'd0;
        step(30);
        wait_an(4'b1101, "zero_an1");
        vectors++;
        if (seg !== 7'b1111111) begin miscompares++; $display("FAIL zero_tens: got %b want 1111111", seg); end
        mode = 1'b1;
        step(1);
        wait_an(4'b0111, "mode_d_an3");
        vectors++;
        if (seg !== 7'b0100001) begin miscompares++; $display("FAIL mode_d: got %b want 0100001", seg); end
        mode = 1'b0;
        step(1);
        wait_an(4'b0111, "mode_u_an3");
        vectors++;
        if (seg !== 7'b1000001) begin miscompares++; $display("FAIL mode_u: got %b want 1000001", seg); end
    endtask

    task automatic test_capture_latency;
        // value is 0 and its conversion has settled.
        sync_capture("lat_sync");
        value = 8'd200;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy_e%0d: got %b want 1", i, busy); end
        end
        step(1);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL lat_busy_e9: got %b want 0", busy); end
        vectors++;
        if ({dut.hund, dut.tens, dut.ones} !== 12'h000) begin
            miscompares++;
            $display("FAIL lat_digits_e9: got %h want 000", {dut.hund, dut.tens, dut.ones});
        end
        step(1);  // next IDLE capture edge, takes 200
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy_cap2: got %b want 1", busy); end
        step(8);
        vectors++;
        if ({dut.hund, dut.tens, dut.ones} !== 12'h000) begin
            miscompares++;
            $display("FAIL lat_digits_early: got %h want 000", {dut.hund, dut.tens, dut.ones});
        end
        step(1);
        vectors++;
        if ({dut.hund, dut.tens, dut.ones} !== 12'h200) begin
            miscompares++;
            $display("FAIL lat_digits_200: got %h want 200", {dut.hund, dut.tens, dut.ones});
        end
    endtask

    task automatic test_reset_mid;
        // value is still 200.
        sync_capture("mid_sync");
        step(4);  // SHIFT with it == 4
        clr = 1'b1;
        #1;
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL mid_an: got %b want 1111", an); end
        vectors++;
        if (seg !== 7'b1111111) begin miscompares++; $display("FAIL mid_seg: got %b want 1111111", seg); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
        vectors++;
        if ({dut.hund, dut.tens, dut.ones} !== 12'h000) begin
            miscompares++;
            $display("FAIL mid_digits: got %h want 000", {dut.hund, dut.tens, dut.ones});
        end
        step(1);
        clr = 1'b0;
        step(1);  // fresh capture edge
        vectors++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            miscompares++;
            $display("FAIL mid_release: got an=%b seg=%b want an=1110 seg=1000000", an, seg);
        end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_e0: got %b want 1", busy); end
        for (int i = 1; i <= 8; i++) begin
            step(1);
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_e%0d: got %b want 1", i, busy); end
        end
        step(1);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy_e9: got %b want 0", busy); end
        vectors++;
        if ({dut.hund, dut.tens, dut.ones} !== 12'h200) begin
            miscompares++;
            $display("FAIL mid_digits_200: got %h want 200", {dut.hund, dut.tens, dut.ones});
        end
        step(1);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_e10: got %b want 1", busy); end
    endtask

    task automatic test_wrap;
        // 255 -> 0 from the counter: each sample converts on its own.
        value = 8'd255;
        step(20);
        value = 8'd0;
        step(20);
        vectors++;
        if ({dut.hund, dut.tens, dut.ones} !== 12'h000) begin
            miscompares++;
            $display("FAIL wrap_0: got %h want 000", {dut.hund, dut.tens, dut.ones});
        end
        value = 8'd99;
        step(20);
        wait_an(4'b1101, "v99_an1");
        vectors++;
        if (seg !== 7'b0010000) begin miscompares++; $display("FAIL v99_tens: got %b want 0010000", seg); end
        wait_an(4'b1011, "v99_an2");
        vectors++;
        if (seg !== 7'b1111111) begin miscompares++; $display("FAIL v99_hund: got %b want 1111111", seg); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr         = 1'b1;
        value       = 8'd0;
        mode        = 1'b0;
        test_reset();
        test_full_range();
        test_blanking();
        test_mode();
        test_capture_latency();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Display back end for the 8-bit up/down counter in the counter/scan design. Takes the counter's `q` value and its count-direction flag, converts the binary value to three BCD digits with a sequential double-dabble engine, and drives a 4-digit multiplexed common-anode seven-segment display. Digits 0–2 show the value in decimal, with leading zeros blanked. Digit 3 shows `U` (counting up) or `d` (counting down).

## Interface
- `SCAN_DIV`, 50000: clk cycles each digit stays lit; minimum 2.
- `clk`  in  1  system clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `value`  in  8  binary value to display (counter `q`).
- `mode`  in  1  direction flag: 0 = up, 1 = down.
- `seg`  out  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
- `an`  out  4  digit enable, one-hot active-low, registered; bit 0 = ones digit, bit 3 = mode letter.
- `busy`  out  1  high while a conversion is in SHIFT or UPDATE.

## Operation
- **Converter FSM:** states IDLE, SHIFT, UPDATE. It loops continuously.
  - **IDLE** (1 cycle):
    - Working register `work[19:0] <= {12'b0, value}`.
    - `it <= 0`.
    - Next state SHIFT.
  - **SHIFT** (exactly 8 cycles):
    - Per cycle, each BCD nibble `work[11:8]`, `work[15:12]`, `work[19:16]` that is ≥5 gets +3.
    - Then the whole 20-bit word shifts left by 1, with 0 shifted in.
    - `it` increments each cycle; after `it == 7`, next state is UPDATE.
  - **UPDATE** (1 cycle):
    - `ones <= work[11:8]`, `tens <= work[15:12]`, `hund <= work[19:16]`.
    - Next state IDLE.
- **Sampling:**
  - `value` is sampled only in IDLE.
  - Changes during SHIFT/UPDATE are ignored until the next IDLE.
  - `mode` is not latched by the converter; the scanner uses it live.
- **Scanner:**
  - 16-bit prescaler counts 0..SCAN_DIV-1.
  - On wrap, `idx` (2-bit) advances 0→1→2→3→0.
- **Digit content:**
  - idx 0: `ones`, always shown.
  - idx 1: `tens`; blank if `hund == 0 && tens == 0`.
  - idx 2: `hund`; blank if `hund == 0`.
  - idx 3: `U` if `mode == 0`, `d` if `mode == 1`.
- **Segment codes** (gfedcba, active-low):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - U = 1000001
  - d = 0100001
  - blank = 1111111
  - Nibbles >9 cannot occur; decode them as blank.
- **Output registers:** every cycle, `an <= ~(4'b0001 << idx)` and `seg <=` the decode for `idx`. The outputs therefore lag `idx` and the digit registers by one cycle.

## Timing
- **Reset values:**
  - FSM = IDLE, `work = 0`, `it = 0`.
  - `ones = tens = hund = 0`.
  - prescaler = 0, `idx = 0`.
  - `an = 4'b1111`, `seg = 7'b1111111`, `busy = 0`.
- **First edge after `clr` deasserts:** `an = 1110`, `seg = 1000000` (digit 0 shows "0").
- **Conversion timing:**
  - Conversion period is 10 cycles.
  - If `value` is captured at edge E0, `ones`/`tens`/`hund` update at E9.
  - The corresponding `seg` update appears at E10, provided idx 0 is selected.
  - Worst-case latency from a `value` change to digit registers: 19 edges.
- **`busy`:** registered from next-state. It is 1 for the 9 cycles following each IDLE capture edge (SHIFT×8 + UPDATE), then 0 for 1 cycle.
- **Scanning:**
  - Each digit is enabled for exactly SCAN_DIV cycles.
  - A full scan takes 4×SCAN_DIV cycles.
  - `an` always has exactly one 0 once out of reset.
- **Digit register updates:** these may change mid-digit. The new code appears on `seg` one cycle after UPDATE. Blanking is evaluated from the current `hund`/`tens`.
- **`clr` asserted at any time** (including mid-SHIFT): all registers return to reset values immediately. The partial conversion is discarded, and a fresh IDLE capture happens on the first edge after release.
- **`value` wrap 255↔0 from the counter:** no special handling; each sample converts independently.

## Test plan
- **Reset:** hold `clr` with `value = 8'd123`.
  - While asserted: `an = 1111`, `seg = 1111111`, `busy = 0`.
  - First edge after release: `an = 1110`, `seg = 1000000`.
- **Full-range conversion** (SCAN_DIV=4), `value = 255`, `mode = 0`, run 30 cycles:
  - `hund/tens/ones = 2/5/5`.
  - Scan shows an 1110 → 0010010, 1101 → 0010010, 1011 → 0100100, 0111 → 1000001.
- **Leading-zero blanking:**
  - `value = 7`: an 1101 and 1011 both give `seg = 1111111`; an 1110 gives 1111000.
  - `value = 100`: an 1101 gives 1000000 (zero not blanked).
- **Mode flag:** `value = 0`, toggle `mode` to 1. When idx 3 is next active, `seg = 0100001`; `mode` back to 0 gives 1000001.
- **Capture/latency:** change `value` 0→200 one cycle after an IDLE capture.
  - `busy` stays 1 for 8 more cycles.
  - Digit registers stay 0/0/0 until the following conversion.
  - `2/0/0` appears exactly 9 edges after the next IDLE capture edge.
- **Reset mid-operation:** with `value = 200`, pulse `clr` during SHIFT `it = 4`.
  - Outputs immediately return to reset values and digit registers clear to 0.
  - After release, `2/0/0` is present within 10 edges and `busy` pattern is 9 high / 1 low.
